// File: rtl/resync_pkg.sv
// Shared helpers for the resync_filter slice: filter counter sizing and edge classification.
// The optional glitch counters are enabled with the RESYNC_GLITCH_CNT_EN macro.
package resync_pkg;

    // The counter has to hold 0..FILT_LEN-1. One spare code keeps FILT_LEN=1 at a legal width.
    function automatic int filt_cnt_w(input int filt_len);
        return (filt_len < 1) ? 1 : $clog2(filt_len + 1);
    endfunction

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_t;

endpackage

// File: rtl/resync_filter_ch.sv
// One channel: NUM_STAGE synchroniser, stability filter, registered rise/fall pulses.
// With RESYNC_GLITCH_CNT_EN defined, a saturating per-channel rejected-glitch counter is added.
module resync_filter_ch
    import resync_pkg::*;
#(
    parameter int   NUM_STAGE = 3,
    parameter int   FILT_LEN  = 4,
    parameter logic RST_VAL   = 1'b0,
    parameter int   GCNT_W    = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              data_i,
`ifdef RESYNC_GLITCH_CNT_EN
    input  logic              glitch_clr_i,
    output logic [GCNT_W-1:0] glitch_cnt_o,
`endif
    output logic              data_o,
    output logic              rise_o,
    output logic              fall_o
);

    localparam int              CNT_W    = filt_cnt_w(FILT_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    typedef struct packed {
        logic [NUM_STAGE-1:0] chain;
        logic                 level;
        logic [CNT_W-1:0]     cnt;
    } ch_state_t;

    ch_state_t st_q;
    ch_state_t st_d;
    edge_t     edge_d;
    logic      sync_s;

    assign sync_s = st_q.chain[NUM_STAGE-1];
    assign data_o = st_q.level;

    always_comb begin
        st_d       = st_q;
        edge_d     = EDGE_NONE;
        st_d.chain = {st_q.chain[NUM_STAGE-2:0], data_i};
        if (sync_s == st_q.level) begin
            st_d.cnt = '0;
        end else if (st_q.cnt == CNT_LAST) begin
            st_d.level = sync_s;
            st_d.cnt   = '0;
            edge_d     = sync_s ? EDGE_RISE : EDGE_FALL;
        end else begin
            st_d.cnt = st_q.cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q.chain <= {NUM_STAGE{RST_VAL}};
            st_q.level <= RST_VAL;
            st_q.cnt   <= '0;
            rise_o     <= 1'b0;
            fall_o     <= 1'b0;
        end else begin
            st_q   <= st_d;
            rise_o <= (edge_d == EDGE_RISE);
            fall_o <= (edge_d == EDGE_FALL);
        end
    end

`ifdef RESYNC_GLITCH_CNT_EN
    // A glitch is a level that fell back to the accepted one before qualifying.
    logic              glitch;
    logic [GCNT_W-1:0] gcnt_q;

    assign glitch       = (sync_s == st_q.level) && (st_q.cnt != '0);
    assign glitch_cnt_o = gcnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gcnt_q <= '0;
        end else if (glitch_clr_i) begin
            gcnt_q <= '0;
        end else if (glitch && (gcnt_q != {GCNT_W{1'b1}})) begin
            gcnt_q <= gcnt_q + GCNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/resync_filter.sv
// Multi-channel input conditioner: NUM_CH independent resync + debounce + edge-detect channels.
// Define RESYNC_GLITCH_CNT_EN to add glitch_clr_i / glitch_cnt_o and the per-channel counters.
module resync_filter
    import resync_pkg::*;
#(
    parameter int                NUM_STAGE = 3,
    parameter int                NUM_CH    = 4,
    parameter int                FILT_LEN  = 4,
    parameter logic [NUM_CH-1:0] RST_VAL   = '0,
    parameter int                GCNT_W    = 8
) (
    input  logic                     rstn,
    input  logic                     clk,
    input  logic [NUM_CH-1:0]        data_i,
    output logic [NUM_CH-1:0]        data_o,
    output logic [NUM_CH-1:0]        rise_o,
`ifdef RESYNC_GLITCH_CNT_EN
    input  logic                     glitch_clr_i,
    output logic [NUM_CH*GCNT_W-1:0] glitch_cnt_o,
`endif
    output logic [NUM_CH-1:0]        fall_o
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        resync_filter_ch #(
            .NUM_STAGE (NUM_STAGE),
            .FILT_LEN  (FILT_LEN),
            .RST_VAL   (RST_VAL[c]),
            .GCNT_W    (GCNT_W)
        ) u_ch (
            .clk          (clk),
            .rstn         (rstn),
            .data_i       (data_i[c]),
`ifdef RESYNC_GLITCH_CNT_EN
            .glitch_clr_i (glitch_clr_i),
            .glitch_cnt_o (glitch_cnt_o[c*GCNT_W +: GCNT_W]),
`endif
            .data_o       (data_o[c]),
            .rise_o       (rise_o[c]),
            .fall_o       (fall_o[c])
        );
    end

endmodule

// File: tb/tb_resync_filter.sv
// Directed self-checking bench for resync_filter (NUM_STAGE=3, FILT_LEN=4, NUM_CH=4).
// Glitch-counter scenarios run only when RESYNC_GLITCH_CNT_EN is defined.
module tb_resync_filter;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] data_i = 4'h0;
    logic [3:0] data_a = 4'hA;
    logic [3:0] data_o, rise_o, fall_o;
    logic [3:0] data_o_a, rise_o_a, fall_o_a;
`ifdef RESYNC_GLITCH_CNT_EN
    logic       glitch_clr_i = 1'b0;
    logic [7:0] glitch_cnt_o, glitch_cnt_o_a;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    resync_filter #(
        .NUM_STAGE (3), .NUM_CH (4), .FILT_LEN (4), .RST_VAL (4'h0), .GCNT_W (2)
    ) dut (
        .rstn         (rstn),
        .clk          (clk),
        .data_i       (data_i),
        .data_o       (data_o),
        .rise_o       (rise_o),
`ifdef RESYNC_GLITCH_CNT_EN
        .glitch_clr_i (glitch_clr_i),
        .glitch_cnt_o (glitch_cnt_o),
`endif
        .fall_o       (fall_o)
    );

    resync_filter #(
        .NUM_STAGE (3), .NUM_CH (4), .FILT_LEN (4), .RST_VAL (4'hA), .GCNT_W (2)
    ) dut_a (
        .rstn         (rstn),
        .clk          (clk),
        .data_i       (data_a),
        .data_o       (data_o_a),
        .rise_o       (rise_o_a),
`ifdef RESYNC_GLITCH_CNT_EN
        .glitch_clr_i (glitch_clr_i),
        .glitch_cnt_o (glitch_cnt_o_a),
`endif
        .fall_o       (fall_o_a)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn   = 1'b0;
        data_i = 4'hF;
        data_a = 4'hF;
        repeat (3) tick();
        n_tests++; if (data_o !== 4'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", data_o); end
        n_tests++; if (rise_o !== 4'h0 || fall_o !== 4'h0) begin n_fail++; $display("FAIL reset_pulse rise %h fall %h exp 0", rise_o, fall_o); end
        n_tests++; if (data_o_a !== 4'hA) begin n_fail++; $display("FAIL reset_rstval got %h exp a", data_o_a); end
`ifdef RESYNC_GLITCH_CNT_EN
        n_tests++; if (glitch_cnt_o !== 8'h00) begin n_fail++; $display("FAIL reset_gcnt got %h exp 00", glitch_cnt_o); end
`endif
        data_i = 4'h0;
        data_a = 4'hA;
        rstn   = 1'b1;
        repeat (10) tick();
        n_tests++; if (data_o !== 4'h0 || data_o_a !== 4'hA) begin n_fail++; $display("FAIL reset_idle got %h/%h exp 0/a", data_o, data_o_a); end
    endtask

    task automatic test_step;
        int bad;
        data_i[0] = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (data_o[0] !== 1'b0 || rise_o !== 4'h0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL step_rise_early %0d early cycles exp 0", bad); end
        tick();
        n_tests++; if (data_o !== 4'h1 || rise_o !== 4'h1 || fall_o !== 4'h0) begin n_fail++; $display("FAIL step_rise data %h rise %h fall %h exp 1/1/0", data_o, rise_o, fall_o); end
        tick();
        n_tests++; if (data_o !== 4'h1 || rise_o !== 4'h0) begin n_fail++; $display("FAIL step_rise_end data %h rise %h exp 1/0", data_o, rise_o); end

        data_i[0] = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (data_o[0] !== 1'b1 || fall_o !== 4'h0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL step_fall_early %0d early cycles exp 0", bad); end
        tick();
        n_tests++; if (data_o !== 4'h0 || fall_o !== 4'h1 || rise_o !== 4'h0) begin n_fail++; $display("FAIL step_fall data %h fall %h rise %h exp 0/1/0", data_o, fall_o, rise_o); end
        tick();
        n_tests++; if (fall_o !== 4'h0) begin n_fail++; $display("FAIL step_fall_end fall %h exp 0", fall_o); end
    endtask

    task automatic test_glitch;
        int bad;
        int rises;
        data_i[1] = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 2) data_i[1] = 1'b0;
            if (data_o[1] !== 1'b0 || rise_o[1] !== 1'b0 || fall_o[1] !== 1'b0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL glitch_reject %0d bad cycles exp 0", bad); end
`ifdef RESYNC_GLITCH_CNT_EN
        n_tests++; if (glitch_cnt_o[3:2] !== 2'd1) begin n_fail++; $display("FAIL glitch_count got %0d exp 1", glitch_cnt_o[3:2]); end
`endif
        data_i[1] = 1'b1;
        rises = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 3) data_i[1] = 1'b0;
            if (rise_o[1] === 1'b1) rises++;
        end
        n_tests++; if (data_o[1] !== 1'b1 || rise_o[1] !== 1'b1 || rises != 1) begin n_fail++; $display("FAIL glitch_accept data %b rise %b count %0d exp 1/1/1", data_o[1], rise_o[1], rises); end
        repeat (10) tick();
        n_tests++; if (data_o[1] !== 1'b0) begin n_fail++; $display("FAIL glitch_return got %b exp 0", data_o[1]); end
`ifdef RESYNC_GLITCH_CNT_EN
        n_tests++; if (glitch_cnt_o[3:2] !== 2'd1) begin n_fail++; $display("FAIL glitch_count_hold got %0d exp 1", glitch_cnt_o[3:2]); end
`endif
    endtask

    task automatic test_simultaneous;
        int bad;
        data_i = 4'hF;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rise_o !== 4'h0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL simul_early %0d early cycles exp 0", bad); end
        tick();
        n_tests++; if (rise_o !== 4'hF || data_o !== 4'hF || fall_o !== 4'h0) begin n_fail++; $display("FAIL simul_rise rise %h data %h fall %h exp f/f/0", rise_o, data_o, fall_o); end
        tick();
        n_tests++; if (rise_o !== 4'h0) begin n_fail++; $display("FAIL simul_rise_end got %h exp 0", rise_o); end
        data_i = 4'h0;
        repeat (6) tick();
        tick();
        n_tests++; if (fall_o !== 4'hF || rise_o !== 4'h0 || data_o !== 4'h0) begin n_fail++; $display("FAIL simul_fall fall %h rise %h data %h exp f/0/0", fall_o, rise_o, data_o); end
        tick();
        n_tests++; if (fall_o !== 4'h0) begin n_fail++; $display("FAIL simul_fall_end got %h exp 0", fall_o); end
    endtask

`ifdef RESYNC_GLITCH_CNT_EN
    task automatic test_saturation;
        for (int g = 0; g < 5; g++) begin
            data_i[2] = 1'b1;
            repeat (3) tick();
            data_i[2] = 1'b0;
            repeat (6) tick();
            if (g == 0) begin
                n_tests++; if (glitch_cnt_o[5:4] !== 2'd1) begin n_fail++; $display("FAIL sat_first got %0d exp 1", glitch_cnt_o[5:4]); end
            end
        end
        n_tests++; if (glitch_cnt_o[5:4] !== 2'd3 || data_o[2] !== 1'b0) begin n_fail++; $display("FAIL sat_hold cnt %0d data %b exp 3/0", glitch_cnt_o[5:4], data_o[2]); end
        data_i[2] = 1'b1;
        repeat (3) tick();
        data_i[2] = 1'b0;
        repeat (3) tick();
        glitch_clr_i = 1'b1;
        tick();
        glitch_clr_i = 1'b0;
        n_tests++; if (glitch_cnt_o !== 8'h00) begin n_fail++; $display("FAIL clear_prio got %h exp 00", glitch_cnt_o); end
        tick();
        n_tests++; if (glitch_cnt_o !== 8'h00) begin n_fail++; $display("FAIL clear_after got %h exp 00", glitch_cnt_o); end
    endtask
`endif

    task automatic test_reset_mid;
        int bad;
        data_i[3] = 1'b1;
        repeat (5) tick();
        rstn = 1'b0;
        #2;
        n_tests++; if (data_o !== 4'h0 || data_o_a !== 4'hA || rise_o !== 4'h0) begin n_fail++; $display("FAIL midrst_state data %h/%h rise %h exp 0/a/0", data_o, data_o_a, rise_o); end
        rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (data_o[3] !== 1'b0 || rise_o[3] !== 1'b0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL midrst_early %0d early cycles exp 0", bad); end
        tick();
        n_tests++; if (data_o[3] !== 1'b1 || rise_o !== 4'h8) begin n_fail++; $display("FAIL midrst_accept data %b rise %h exp 1/8", data_o[3], rise_o); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_simultaneous();
`ifdef RESYNC_GLITCH_CNT_EN
        test_saturation();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
